cr16_ctrl_fsm: RTL

Multi-cycle control unit for the CR16-style regfile/ALU datapath. It arbitrates between two requesters:
- an instruction source;
- an external register-load port.

It decodes each accepted instruction into register addresses, ALU opcode and immediate operand. It sequences FETCH → DECODE → EXEC → WB, driving the mux selects and one-hot register write enables. It owns the processor flag register.

---
 rtl/cr16_ctrl_fsm_if.sv | 35 +++
 rtl/cr16_ctrl_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/cr16_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the CR16 control FSM (slave)
// and its requesters and datapath (master).
interface cr16_ctrl_fsm_if #(
  parameter int NREGS = 16
);
  logic              instr_valid;
  logic [15:0]       instr;
  logic              instr_ready;
  logic              ext_wr_valid;
  logic [3:0]        ext_wr_addr;
  logic              ext_wr_ready;
  logic [3:0]        raddr_a;
  logic [3:0]        raddr_b;
  logic [3:0]        alu_op;
  logic [15:0]       imm;
  logic              imm_sel;
  logic              wb_sel;
  logic [NREGS-1:0]  reg_en;
  logic [4:0]        alu_flags;
  logic [4:0]        flags;
  logic              done;
  logic              illegal;

  modport master (
    output instr_valid, instr, ext_wr_valid, ext_wr_addr, alu_flags,
    input  instr_ready, ext_wr_ready, raddr_a, raddr_b, alu_op, imm,
           imm_sel, wb_sel, reg_en, flags, done, illegal
  );

  modport slave (
    input  instr_valid, instr, ext_wr_valid, ext_wr_addr, alu_flags,
    output instr_ready, ext_wr_ready, raddr_a, raddr_b, alu_op, imm,
           imm_sel, wb_sel, reg_en, flags, done, illegal
  );
endinterface

// File: rtl/cr16_ctrl_fsm.sv
// CR16 multi-cycle control unit: FETCH/DECODE/EXEC/WB sequencing, decode and flags.
// Optional build macro CTRL_SIGN_EXT_IMM_EN sign-extends the I-type immediate.
module cr16_ctrl_fsm #(
  parameter int NREGS = 16
) (
  input  logic            clk,
  input  logic            reset,
  cr16_ctrl_fsm_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [3:0] OP_MOV = 4'hD;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  flags_q, flags_d;

  logic        r_type;
  logic [3:0]  op;
  logic [3:0]  rdest;
  logic [3:0]  rsrc;
  logic [15:0] imm_ext;
  logic        legal;
  logic        writes_reg;
  logic        sets_flags;

  function automatic logic [NREGS-1:0] onehot(input logic [AW-1:0] addr);
    logic [NREGS-1:0] v;
    v = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Instruction decode is purely a function of IR, so the datapath fields
  // stay stable for the whole DECODE..WB window.
  always_comb begin
    r_type     = (ir_q[15:12] == 4'h0);
    rdest      = ir_q[11:8];
    op         = r_type ? ir_q[7:4] : ir_q[15:12];
    rsrc       = r_type ? ir_q[3:0] : 4'h0;
    legal      = 1'b0;
    writes_reg = 1'b0;
    sets_flags = 1'b0;
    if (r_type) begin
      imm_ext = 16'h0000;
    end else begin
`ifdef CTRL_SIGN_EXT_IMM_EN
      imm_ext = {{8{ir_q[7]}}, ir_q[7:0]};
`else
      imm_ext = {8'h00, ir_q[7:0]};
`endif
    end
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_MOV: begin
        legal      = 1'b1;
        writes_reg = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        legal      = 1'b1;
        writes_reg = 1'b1;
        sets_flags = 1'b1;
      end
      OP_CMP: begin
        legal      = 1'b1;
        sets_flags = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    ir_d             = ir_q;
    flags_d          = flags_q;
    bus.instr_ready  = 1'b0;
    bus.ext_wr_ready = 1'b0;
    bus.imm_sel      = 1'b0;
    bus.wb_sel       = 1'b0;
    bus.reg_en       = '0;
    bus.done         = 1'b0;
    bus.illegal      = 1'b0;

    case (state_q)
      S_FETCH: begin
        // External loads win over instructions and complete in this cycle.
        if (bus.ext_wr_valid) begin
          bus.ext_wr_ready = 1'b1;
          bus.reg_en       = onehot(bus.ext_wr_addr[AW-1:0]);
        end else begin
          bus.instr_ready = 1'b1;
          if (bus.instr_valid) begin
            ir_d    = bus.instr;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        bus.imm_sel = ~r_type;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        bus.imm_sel = ~r_type;
        if (sets_flags) begin
          flags_d = bus.alu_flags;
        end
        state_d = S_WB;
      end
      S_WB: begin
        bus.imm_sel = ~r_type;
        bus.wb_sel  = 1'b1;
        bus.done    = 1'b1;
        bus.illegal = ~legal;
        if (writes_reg) begin
          bus.reg_en = onehot(rdest[AW-1:0]);
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.raddr_a = rdest;
  assign bus.raddr_b = rsrc;
  assign bus.alu_op  = op;
  assign bus.imm     = imm_ext;
  assign bus.flags   = flags_q;

endmodule
